mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Sits directly upstream of the memory system wrapper in the multicycle MIPS datapath.
- Takes one memory request at a time from the multicycle control unit. Selects PC or ALUOut as the address (IorD) and checks alignment and region.
- Drives the memory system's address, write-enable and write-data inputs.
- Captures read data into the Instruction Register (IR) or Memory Data Register (MDR), then reports completion or a fault.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, address bus width.
- ROM_BASE, 32'h0040_0000, first byte address of program ROM.
- ROM_WORDS, 64, ROM size in words.
- RAM_BASE, 32'h1001_0000, first byte address of data RAM.
- RAM_WORDS, 64, RAM size in words.
- READ_LATENCY, 1, cycles from address presentation to valid ms_rdata_i (1..4).

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- req_valid_i  in  1  control requests a memory access.
- req_ready_o  out  1  unit is idle and accepts a request.
- iord_i  in  1  0: address = pc_i; 1: address = alu_addr_i.
- we_i  in  1  1: write access; 0: read access.
- ir_write_i  in  1  on a read, 1 captures into IR, 0 captures into MDR.
- pc_i  in  ADDR_WIDTH  program counter.
- alu_addr_i  in  ADDR_WIDTH  ALUOut register value.
- wdata_i  in  DATA_WIDTH  store data (register B).
- ms_addr_o  out  ADDR_WIDTH  address to memory system.
- ms_we_o  out  1  write enable to memory system.
- ms_wdata_o  out  DATA_WIDTH  write data to memory system.
- ms_rdata_i  in  DATA_WIDTH  read data from memory system.
- instr_o  out  DATA_WIDTH  IR contents.
- mdr_o  out  DATA_WIDTH  MDR contents.
- done_o  out  1  one-cycle completion pulse.
- fault_o  out  1  valid with done_o: access rejected.

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous and active-high on rst_i.
- Reset values: state IDLE; req_ready_o=1; ms_we_o=0; ms_addr_o, ms_wdata_o, instr_o, mdr_o = 0; done_o=0; fault_o=0.
- Reset asserted mid-operation: immediately returns to IDLE, drops ms_we_o and clears IR/MDR. No done_o is issued for the aborted request.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i=1 at a clock edge, the unit latches the selected address, wdata_i, we_i and ir_write_i.
  - Fault checks on the latched request:
    - misaligned: addr[1:0] != 0;
    - unmapped: address in neither [ROM_BASE, ROM_BASE+4*ROM_WORDS) nor [RAM_BASE, RAM_BASE+4*RAM_WORDS);
    - write to ROM: we_i=1 with a ROM address.
  - Faulting request -> RESP with fault pending. Otherwise -> ACCESS.
- ACCESS:
  - ms_addr_o holds the latched address. req_ready_o=0.
  - Write: ms_we_o=1 for exactly this one cycle, ms_wdata_o = latched data, then -> RESP.
  - Read: ms_we_o=0. A counter counts READ_LATENCY cycles. On the edge ending the last ACCESS cycle, ms_rdata_i is loaded into IR (ir_write=1) or MDR (ir_write=0), then -> RESP.
- RESP:
  - done_o=1 for one cycle. fault_o=1 only for a faulted request. req_ready_o=0. Next state IDLE.
- Latency, counting the acceptance edge as edge 0:
  - write: done_o high in cycle 2;
  - read: done_o high in cycle READ_LATENCY+1;
  - fault: done_o high in cycle 1.
- A new request is accepted in the cycle after done_o, giving no back-to-back overlap.
- req_valid_i while req_ready_o=0 is ignored. Control holds it until accepted.
- Faulted request: no ms_we_o pulse; IR and MDR unchanged; ms_addr_o keeps its previous value.
- ms_addr_o, ms_wdata_o, IR and MDR hold their values between accesses. The IR is not overwritten by MDR loads, and vice versa.
- Region bounds: the last valid word is BASE+4*(WORDS-1); BASE+4*WORDS is unmapped. Address comparisons use full ADDR_WIDTH, and BASE+4*WORDS is assumed not to wrap past 2^ADDR_WIDTH.

Decomposition:
- Package mips_mem_pkg holds:
  - the state enum (IDLE/ACCESS/RESP);
  - ROM_BASE/RAM_BASE default constants;
  - a fault-cause enum (NONE, MISALIGN, UNMAPPED, ROM_WRITE), exposed internally for debug.
- One natural sub-module: addr_region_check. It is combinational and takes the address and we, returning is_rom, is_ram and fault cause. It is reusable by the memory system wrapper's decoder.

Test Plan:
- Reset mid-read (assert rst_i during ACCESS) -> outputs return to reset values asynchronously; no done_o; next request accepted normally.
- Fetch: iord=0, pc=32'h0040_0004, ir_write=1, ms_rdata_i=32'h2010_0005 -> ms_addr_o=32'h0040_0004, ms_we_o never 1, instr_o=32'h2010_0005, done_o at cycle READ_LATENCY+1, mdr_o unchanged.
- Store: iord=1, alu_addr=32'h1001_0008, we=1, wdata=32'h2 -> ms_we_o=1 for exactly one cycle with ms_addr_o=32'h1001_0008, ms_wdata_o=32'h2; done_o in cycle 2, fault_o=0.
- Load then fetch: load 32'h1001_001C (MDR=32'h7), then fetch 32'h0040_0000 -> mdr_o stays 32'h7 after the fetch completes; instr_o updates.
- Faults: write to 32'h0040_0000, read of 32'h1001_0002, read of 32'h1001_0100 -> each gives done_o=fault_o=1 in cycle 1 with no ms_we_o pulse and IR/MDR unchanged.
- Boundary: read 32'h0040_00FC succeeds; read 32'h0040_0100 faults; with READ_LATENCY=3, done_o arrives in cycle 4.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and default constants for the multicycle MIPS memory access path.
package mips_mem_pkg;

    // Request sequencing states of the access unit.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Reason a request was rejected; NONE means the access goes to memory.
    typedef enum logic [1:0] {
        NONE      = 2'd0,
        MISALIGN  = 2'd1,
        UNMAPPED  = 2'd2,
        ROM_WRITE = 2'd3
    } fault_cause_t;

    // Region the accepted access targets.
    typedef struct packed {
        logic rom;
        logic ram;
    } region_t;

    localparam logic [31:0] DEFAULT_ROM_BASE  = 32'h0040_0000;
    localparam int          DEFAULT_ROM_WORDS = 64;
    localparam logic [31:0] DEFAULT_RAM_BASE  = 32'h1001_0000;
    localparam int          DEFAULT_RAM_WORDS = 64;

    // True when a checker result lets the access proceed to memory.
    function automatic logic cause_is_clean(input fault_cause_t cause);
        return cause == NONE;
    endfunction

endpackage

// File: rtl/addr_region_check.sv
// Combinational address decoder: classifies an address as ROM / RAM and
// reports why an access to it would be rejected. Also usable by the memory
// system wrapper's decoder.
module addr_region_check
    import mips_mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] ROM_BASE   = ADDR_WIDTH'(DEFAULT_ROM_BASE),
    parameter int                    ROM_WORDS  = DEFAULT_ROM_WORDS,
    parameter logic [ADDR_WIDTH-1:0] RAM_BASE   = ADDR_WIDTH'(DEFAULT_RAM_BASE),
    parameter int                    RAM_WORDS  = DEFAULT_RAM_WORDS
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    output logic                  is_rom,
    output logic                  is_ram,
    output fault_cause_t          cause
);

    // Exclusive upper bounds; regions are assumed not to wrap the address space.
    localparam logic [ADDR_WIDTH-1:0] ROM_LIMIT = ROM_BASE + ADDR_WIDTH'(4 * ROM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] RAM_LIMIT = RAM_BASE + ADDR_WIDTH'(4 * RAM_WORDS);

    // Region membership and fault priority: alignment, then mapping, then ROM write.
    always_comb begin
        is_rom = (addr >= ROM_BASE) && (addr < ROM_LIMIT);
        is_ram = (addr >= RAM_BASE) && (addr < RAM_LIMIT);
        cause  = NONE;
        if (addr[1:0] != 2'b00) begin
            cause = MISALIGN;
        end else if (!is_rom && !is_ram) begin
            cause = UNMAPPED;
        end else if (we && is_rom) begin
            cause = ROM_WRITE;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit for the multicycle MIPS datapath. Accepts one request at
// a time, drives the memory system, captures read data into IR or MDR and
// reports completion or a fault with a one-cycle done pulse.
//
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both high; req_ready_o is high only in IDLE, so valid while
// busy is simply not taken and control keeps it asserted until it is.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] ROM_BASE     = ADDR_WIDTH'(DEFAULT_ROM_BASE),
    parameter int                    ROM_WORDS    = DEFAULT_ROM_WORDS,
    parameter logic [ADDR_WIDTH-1:0] RAM_BASE     = ADDR_WIDTH'(DEFAULT_RAM_BASE),
    parameter int                    RAM_WORDS    = DEFAULT_RAM_WORDS,
    parameter int                    READ_LATENCY = 1   // legal range 1..4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  iord_i,
    input  logic                  we_i,
    input  logic                  ir_write_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic [ADDR_WIDTH-1:0] alu_addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [ADDR_WIDTH-1:0] ms_addr_o,
    output logic                  ms_we_o,
    output logic [DATA_WIDTH-1:0] ms_wdata_o,
    input  logic [DATA_WIDTH-1:0] ms_rdata_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] mdr_o
    ,
    output logic                  done_o,
    output logic                  fault_o
);

    // Wide enough for READ_LATENCY up to 4.
    localparam int             CNT_W    = 3;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(READ_LATENCY - 1);

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_is_rom;
    logic                  sel_is_ram;
    fault_cause_t          sel_cause;
    logic                  req_ok;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q;
    logic                  ir_write_q;
    region_t               region_q;
    fault_cause_t          cause_q;     // debug: cause of the last accepted request
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] ir_q;
    logic [DATA_WIDTH-1:0] mdr_q;

    logic                  accept;
    logic                  cnt_inc;
    logic                  load_rd;

    // IorD address select ahead of the region checker.
    always_comb begin
        sel_addr = iord_i ? alu_addr_i : pc_i;
    end

    addr_region_check #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ROM_BASE   (ROM_BASE),
        .ROM_WORDS  (ROM_WORDS),
        .RAM_BASE   (RAM_BASE),
        .RAM_WORDS  (RAM_WORDS)
    ) u_check (
        .addr   (sel_addr),
        .we     (we_i),
        .is_rom (sel_is_rom),
        .is_ram (sel_is_ram),
        .cause  (sel_cause)
    );

    // A request goes to memory only when it is clean and lands in a mapped region.
    always_comb begin
        req_ok = cause_is_clean(sel_cause) && (sel_is_rom || sel_is_ram);
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake / strobe decode.
    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        ms_we_o     = 1'b0;
        done_o      = 1'b0;
        fault_o     = 1'b0;
        accept      = 1'b0;
        cnt_inc     = 1'b0;
        load_rd     = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    accept  = 1'b1;
                    state_d = req_ok ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    // Single-cycle write strobe; writes can only target RAM.
                    ms_we_o = region_q.ram;
                    state_d = RESP;
                end else if (cnt_q == LAST_CNT) begin
                    load_rd = region_q.rom || region_q.ram;
                    state_d = RESP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RESP: begin
                done_o  = 1'b1;
                fault_o = !cause_is_clean(cause_q);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request latch: faulted requests leave the bus-facing registers untouched.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            ir_write_q <= 1'b0;
            region_q   <= '0;
            cause_q    <= NONE;
        end else if (accept) begin
            cause_q <= sel_cause;
            if (req_ok) begin
                addr_q     <= sel_addr;
                wdata_q    <= wdata_i;
                we_q       <= we_i;
                ir_write_q <= ir_write_i;
                region_q   <= '{rom: sel_is_rom, ram: sel_is_ram};
            end
        end
    end

    // Read latency counter: restarts on every accepted request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (cnt_inc) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // IR / MDR capture on the edge that ends the last read cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ir_q  <= '0;
            mdr_q <= '0;
        end else if (load_rd) begin
            if (ir_write_q) begin
                ir_q <= ms_rdata_i;
            end else begin
                mdr_q <= ms_rdata_i;
            end
        end
    end

    // Registered values go straight to the memory system and datapath.
    always_comb begin
        ms_addr_o  = addr_q;
        ms_wdata_o = wdata_q;
        instr_o    = ir_q;
        mdr_o      = mdr_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (instance built with READ_LATENCY=3).
module tb_mem_access_unit;

    localparam int          RL     = 3;
    localparam logic [31:0] ROM_B  = 32'h0040_0000;
    localparam logic [31:0] RAM_B  = 32'h1001_0000;
    localparam logic [31:0] REG_SZ = 32'd256;   // 64 words * 4 bytes

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        iord_i;
    logic        we_i;
    logic        ir_write_i;
    logic [31:0] pc_i;
    logic [31:0] alu_addr_i;
    logic [31:0] wdata_i;
    logic [31:0] ms_addr_o;
    logic        ms_we_o;
    logic [31:0] ms_wdata_o;
    logic [31:0] ms_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] mdr_o;
    logic        done_o;
    logic        fault_o;

    // Clock.
    always #5 clk_i = ~clk_i;

    mem_access_unit #(.READ_LATENCY(RL)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .iord_i      (iord_i),
        .we_i        (we_i),
        .ir_write_i  (ir_write_i),
        .pc_i        (pc_i),
        .alu_addr_i  (alu_addr_i),
        .wdata_i     (wdata_i),
        .ms_addr_o   (ms_addr_o),
        .ms_we_o     (ms_we_o),
        .ms_wdata_o  (ms_wdata_o),
        .ms_rdata_i  (ms_rdata_i),
        .instr_o     (instr_o),
        .mdr_o       (mdr_o),
        .done_o      (done_o),
        .fault_o     (fault_o)
    );

    int checks   = 0;
    int failures = 0;

    // Scoreboard and architectural model state.
    logic [31:0] exp_q[$];
    logic [31:0] m_ir   = '0;
    logic [31:0] m_mdr  = '0;
    logic [31:0] m_addr = '0;

    typedef struct {
        logic        iord;
        logic        we;
        logic        irw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          exp_done;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Access rules: word aligned, inside ROM or RAM, and no stores to ROM.
    function automatic logic model_fault(input logic [31:0] a, input logic w);
        logic in_rom;
        logic in_ram;
        in_rom = (a >= ROM_B) && (a < ROM_B + REG_SZ);
        in_ram = (a >= RAM_B) && (a < RAM_B + REG_SZ);
        return (a % 4 != 0) || !(in_rom || in_ram) || (w && in_rom);
    endfunction

    // Drive one request, play the memory with RL-cycle read latency, and score it.
    task automatic run_req(input logic iord, input logic we, input logic irw,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int exp_done,
                           input logic exp_fault);
        int          waited;
        int          done_c;
        int          we_cnt;
        logic        f_seen;
        logic [31:0] we_a;
        logic [31:0] we_d;
        // Model update and expected results.
        if (!exp_fault) begin
            m_addr = addr;
            if (!we) begin
                if (irw) m_ir = rd;
                else     m_mdr = rd;
            end
        end
        exp_q.push_back(32'(exp_done));
        exp_q.push_back({31'd0, exp_fault});
        exp_q.push_back((we && !exp_fault) ? 32'd1 : 32'd0);
        exp_q.push_back(m_addr);
        exp_q.push_back(m_ir);
        exp_q.push_back(m_mdr);

        waited = 0;
        @(negedge clk_i);
        while (!req_ready_o && waited < 20) begin
            @(negedge clk_i);
            waited++;
        end
        if (!req_ready_o) chk("ready_timeout", {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1;
        iord_i      = iord;
        we_i        = we;
        ir_write_i  = irw;
        pc_i        = iord ? $urandom : addr;
        alu_addr_i  = iord ? addr : $urandom;
        wdata_i     = wd;
        @(posedge clk_i);
        #1;
        // Garbage on the request inputs while busy must be ignored.
        req_valid_i = 1'b0;
        iord_i      = 1'($urandom_range(0, 1));
        we_i        = 1'($urandom_range(0, 1));
        ir_write_i  = 1'($urandom_range(0, 1));
        pc_i        = $urandom;
        alu_addr_i  = $urandom;
        wdata_i     = $urandom;
        done_c = 0;
        we_cnt = 0;
        f_seen = 1'b0;
        we_a   = '0;
        we_d   = '0;
        for (int c = 1; c <= 12 && done_c == 0; c++) begin
            ms_rdata_i  = (c == RL) ? rd : ~rd;
            req_valid_i = (c < exp_done) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (ms_we_o) begin
                we_cnt++;
                we_a = ms_addr_o;
                we_d = ms_wdata_o;
            end
            if (done_o) begin
                done_c = c;
                f_seen = fault_o;
            end else begin
                @(posedge clk_i);
                #1;
            end
        end
        req_valid_i = 1'b0;
        chk("done_cycle", 32'(done_c), exp_q.pop_front());
        chk("fault", {31'd0, f_seen}, exp_q.pop_front());
        chk("we_pulses", 32'(we_cnt), exp_q.pop_front());
        chk("ms_addr", ms_addr_o, exp_q.pop_front());
        chk("instr", instr_o, exp_q.pop_front());
        chk("mdr", mdr_o, exp_q.pop_front());
        chk("ready_in_resp", {31'd0, req_ready_o}, 32'd0);
        if (we && !exp_fault) begin
            chk("we_addr", we_a, addr);
            chk("we_data", we_d, wd);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, {31'd0, req_ready_o}, 32'd1);
        chk({tag, "_we"}, {31'd0, ms_we_o}, 32'd0);
        chk({tag, "_addr"}, ms_addr_o, 32'd0);
        chk({tag, "_wdata"}, ms_wdata_o, 32'd0);
        chk({tag, "_instr"}, instr_o, 32'd0);
        chk({tag, "_mdr"}, mdr_o, 32'd0);
        chk({tag, "_done"}, {31'd0, done_o}, 32'd0);
        chk({tag, "_fault"}, {31'd0, fault_o}, 32'd0);
    endtask

    initial begin
        int          dones;
        logic        r_iord;
        logic        r_we;
        logic        r_irw;
        logic [31:0] r_addr;
        logic        r_flt;

        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        iord_i      = 1'b0;
        we_i        = 1'b0;
        ir_write_i  = 1'b0;
        pc_i        = '0;
        alu_addr_i  = '0;
        wdata_i     = '0;
        ms_rdata_i  = '0;

        // Reset state.
        repeat (2) @(negedge clk_i);
        check_reset_values("reset");
        rst_i = 1'b0;

        // Directed vectors: {iord, we, irw, addr, wdata, rdata, done cycle, fault}.
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'h0040_0004, 32'h0,         32'h2010_0005, 4, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h1001_0008, 32'h2,         32'h0,         2, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h1001_001C, 32'h0,         32'h7,         4, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h0040_0000, 32'h0,         32'h8C09_0000, 4, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h0040_0000, 32'h55,        32'h0,         1, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h1001_0002, 32'h0,         32'h1111_1111, 1, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h1001_0100, 32'h0,         32'h2222_2222, 1, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h0040_00FC, 32'h0,         32'h1234_5678, 4, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h0040_0100, 32'h0,         32'h3333_3333, 1, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h1001_00FC, 32'hA5A5_5A5A, 32'h0,         2, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h003F_FFFC, 32'h0,         32'h4444_4444, 1, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h1001_0000, 32'h0,         32'hDEAD_BEEF, 4, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h0040_0001, 32'h0,         32'h5555_5555, 1, 1'b1};
        for (int i = 0; i < 13; i++) begin
            run_req(vecs[i].iord, vecs[i].we, vecs[i].irw, vecs[i].addr,
                    vecs[i].wdata, vecs[i].rdata, vecs[i].exp_done, vecs[i].exp_fault);
        end

        // Reset in the middle of a read: async return to reset values, no done.
        @(negedge clk_i);
        req_valid_i = 1'b1;
        iord_i      = 1'b1;
        we_i        = 1'b0;
        ir_write_i  = 1'b0;
        alu_addr_i  = 32'h1001_0010;
        pc_i        = 32'h0;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        ms_rdata_i  = 32'h9999_9999;
        @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        #1;
        check_reset_values("midreset");
        @(negedge clk_i);
        rst_i  = 1'b0;
        m_ir   = '0;
        m_mdr  = '0;
        m_addr = '0;
        dones  = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            if (done_o) dones++;
        end
        chk("midreset_no_done", 32'(dones), 32'd0);
        run_req(1'b0, 1'b0, 1'b1, 32'h0040_0008, 32'h0, 32'h0BAD_F00D, RL + 1, 1'b0);

        // Randomized requests scored against the access-rule model.
        for (int n = 0; n < 40; n++) begin
            r_iord = 1'($urandom_range(0, 1));
            r_we   = 1'($urandom_range(0, 1));
            r_irw  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       r_addr = ROM_B + 32'($urandom_range(0, 63)) * 4;
                1:       r_addr = RAM_B + 32'($urandom_range(0, 63)) * 4;
                2:       r_addr = RAM_B + 32'($urandom_range(0, 255));
                3:       r_addr = $urandom;
                default: r_addr = ($urandom_range(0, 1) != 0) ? ROM_B + REG_SZ : RAM_B - 32'd4;
            endcase
            r_flt = model_fault(r_addr, r_we);
            run_req(r_iord, r_we, r_irw, r_addr, $urandom, $urandom,
                    r_flt ? 1 : (r_we ? 2 : RL + 1), r_flt);
        end

        repeat (2) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
